// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_pkg
//  Description : Shared constants and types for the trigger/command merger:
//                stream word width, the idle filler and sync alignment words,
//                and the trigger capture FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trig_pkg;

  localparam int unsigned        C_WORD_W    = 16;
  localparam logic [C_WORD_W-1:0] C_IDLE_WORD = 16'hAAAA;
  localparam logic [C_WORD_W-1:0] C_SYNC_WORD = 16'h817E;

  // Capture FSM: IDLE waits for the encoder, WAIT covers the one-cycle lag of
  // enc_trig behind trigger_rdy, CAPTURE stores the word and pulses trig_clr,
  // CLEAR waits for the encoder to drop trigger_rdy.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_CLEAR   = 2'd3
  } cap_state_e;

endpackage : trig_pkg
`default_nettype wire

// File: rtl/trig_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trig_fifo
//  Description : Synchronous show-ahead FIFO for captured trigger words.
//                pop_data_o always shows the head entry; push and pop in the
//                same cycle keep the level unchanged and preserve order.
//  Ports       : clk160, rst          - clock, synchronous active-high reset
//                push_i, push_data_i  - write request / data (ignored if full)
//                pop_i                - consume head entry (ignored if empty)
//                pop_data_o           - head entry
//                full_o, empty_o      - status flags
//                level_o              - registered occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_fifo
  import trig_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk160,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [C_WORD_W-1:0]       push_data_i,
  input  logic                      pop_i,
  output logic [C_WORD_W-1:0]       pop_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [C_WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [LVL_W-1:0]    level_q;

  logic w_push;
  logic w_pop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign w_push     = push_i & ~full_o;
  assign w_pop      = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk160) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule : trig_fifo
`default_nettype wire

// File: rtl/trig_cmd_merge.sv
`default_nettype none
// ============================================================================
//  Module      : trig_cmd_merge
//  Description : Captures encoded trigger words from the trigger encoder into
//                a small FIFO (handshaking with trig_clr) and merges trigger
//                words, command words and periodic sync words into one
//                continuous 16-bit word stream. Slot priority: sync, trigger,
//                command, idle filler.
//  Ports       : clk160, rst              - clock, synchronous active-high reset
//                trigger_rdy, enc_trig    - encoder pattern-held flag / word
//                trig_clr                 - one-cycle clear pulse to encoder
//                cmd_valid, cmd_data      - command offer
//                cmd_ready                - command accepted (combinational)
//                out_ready                - downstream consumes out_data
//                out_valid, out_data      - output stream
//                fifo_level               - trigger FIFO occupancy
//                trig_ovf                 - sticky trigger-dropped flag
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_cmd_merge
  import trig_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH  = 4,
  parameter int unsigned          SYNC_PERIOD = 32,
  parameter logic [C_WORD_W-1:0]  IDLE_WORD   = C_IDLE_WORD,
  parameter logic [C_WORD_W-1:0]  SYNC_WORD   = C_SYNC_WORD
) (
  input  logic                          clk160,
  input  logic                          rst,
  input  logic                          trigger_rdy,
  input  logic [C_WORD_W-1:0]           enc_trig,
  output logic                          trig_clr,
  input  logic                          cmd_valid,
  input  logic [C_WORD_W-1:0]           cmd_data,
  output logic                          cmd_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [C_WORD_W-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          trig_ovf
);

  localparam int unsigned CNT_W = $clog2(SYNC_PERIOD);

  // --------------------------------------------------------------------------
  // Trigger FIFO
  // --------------------------------------------------------------------------
  logic                 w_push;
  logic                 w_pop;
  logic [C_WORD_W-1:0]  w_fifo_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  trig_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_trig_fifo (
    .clk160      (clk160),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (enc_trig),
    .pop_i       (w_pop),
    .pop_data_o  (w_fifo_head),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .level_o     (fifo_level)
  );

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  cap_state_e state_q;
  logic       trig_clr_q;
  logic       trig_ovf_q;

  // Fullness is taken from the registered level, i.e. before any pop that
  // happens in the same cycle, so a full FIFO drops the word even if the
  // arbiter is draining it right now.
  assign w_push = (state_q == ST_CAPTURE) & ~w_fifo_full;

  always_ff @(posedge clk160) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      trig_clr_q <= 1'b0;
      trig_ovf_q <= 1'b0;
    end else begin
      trig_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger_rdy) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // trig_clr is registered, so raise it on entry to CAPTURE.
          state_q    <= ST_CAPTURE;
          trig_clr_q <= 1'b1;
        end
        ST_CAPTURE: begin
          if (w_fifo_full) begin
            trig_ovf_q <= 1'b1;
          end
          state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (!trigger_rdy) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trig_clr = trig_clr_q;
  assign trig_ovf = trig_ovf_q;

  // --------------------------------------------------------------------------
  // Output slot arbiter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]    sync_cnt_q;
  logic [CNT_W-1:0]    sync_cnt_d;
  logic [C_WORD_W-1:0] out_data_q;
  logic [C_WORD_W-1:0] out_data_d;
  logic                out_valid_q;
  logic                w_sync_due;
  logic [C_WORD_W-1:0] w_sel_word;

  assign w_sync_due = (sync_cnt_q == CNT_W'(SYNC_PERIOD - 1));

  always_comb begin
    w_sel_word = IDLE_WORD;
    w_pop      = 1'b0;
    if (w_sync_due) begin
      w_sel_word = SYNC_WORD;
    end else if (!w_fifo_empty) begin
      w_sel_word = w_fifo_head;
      w_pop      = out_ready;
    end else if (cmd_valid) begin
      w_sel_word = cmd_data;
    end
  end

  assign cmd_ready = out_ready & ~w_sync_due & w_fifo_empty & ~rst;

  always_comb begin
    sync_cnt_d = sync_cnt_q;
    out_data_d = out_data_q;
    if (out_ready) begin
      out_data_d = w_sel_word;
      sync_cnt_d = w_sync_due ? '0 : sync_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= IDLE_WORD;
      sync_cnt_q  <= '0;
    end else begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
      sync_cnt_q  <= sync_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule : trig_cmd_merge
`default_nettype wire

// File: tb/tb_trig_cmd_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_trig_cmd_merge
//  Description : Randomised self-checking bench for trig_cmd_merge. A driver
//                acts as trigger encoder, command source and stream consumer;
//                a reference model predicts the stream into a scoreboard
//                queue that a separate monitor drains and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_cmd_merge;

  localparam int          DEPTH  = 4;
  localparam int          PERIOD = 32;
  localparam logic [15:0] IDLE   = 16'hAAAA;
  localparam logic [15:0] SYNC   = 16'h817E;
  localparam int          N_CYC  = 3000;
  localparam int          RST_AT = 1340;

  logic        clk160      = 1'b0;
  logic        rst         = 1'b1;
  logic        trigger_rdy = 1'b0;
  logic [15:0] enc_trig    = 16'h0000;
  logic        cmd_valid   = 1'b0;
  logic [15:0] cmd_data    = 16'h0000;
  logic        out_ready   = 1'b0;
  logic        trig_clr;
  logic        cmd_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic        trig_ovf;

  int checks = 0;
  int errors = 0;

  trig_cmd_merge #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_PERIOD (PERIOD),
    .IDLE_WORD   (IDLE),
    .SYNC_WORD   (SYNC)
  ) dut (
    .clk160      (clk160),
    .rst         (rst),
    .trigger_rdy (trigger_rdy),
    .enc_trig    (enc_trig),
    .trig_clr    (trig_clr),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fifo_level  (fifo_level),
    .trig_ovf    (trig_ovf)
  );

  always #3 clk160 = ~clk160;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: trigger words live in a queue, the slot counter is a
  // plain integer, and the capture handshake is tracked as the number of
  // cycles since the encoder raised trigger_rdy (0 = nothing in progress,
  // 1 = enc_trig not yet valid, 2 = capture cycle, 3 = waiting for release).
  // --------------------------------------------------------------------------
  logic [15:0] m_fifo[$];
  logic [15:0] exp_q[$];
  int          m_sync  = 0;
  int          m_age   = 0;
  bit          m_ovf   = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_live  = 1'b0;

  always @(posedge clk160) begin : p_model
    int          size_before;
    logic [15:0] w;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      exp_q.push_back(IDLE);
      m_sync  = 0;
      m_age   = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_live  = 1'b1;
    end else if (m_live) begin
      size_before = m_fifo.size();
      m_valid     = 1'b1;
      if (out_ready) begin
        if (m_sync == PERIOD - 1) begin
          w      = SYNC;
          m_sync = 0;
        end else begin
          m_sync = m_sync + 1;
          if (m_fifo.size() > 0)  w = m_fifo.pop_front();
          else if (cmd_valid)     w = cmd_data;
          else                    w = IDLE;
        end
        exp_q.push_back(w);
      end
      if (m_age == 0) begin
        if (trigger_rdy) m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        if (size_before >= DEPTH) m_ovf = 1'b1;
        else                      m_fifo.push_back(enc_trig);
        m_age = 3;
      end else if (!trigger_rdy) begin
        m_age = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: takes the next predicted word whenever one is queued and holds
  // the last one otherwise, so held words are checked as well.
  // --------------------------------------------------------------------------
  logic [15:0] m_last = IDLE;

  always @(negedge clk160) begin
    if (m_live) begin
      if (exp_q.size() > 0) m_last = exp_q.pop_front();
      check("out_data",   {16'h0, out_data},   {16'h0, m_last});
      check("out_valid",  {31'h0, out_valid},  {31'h0, m_valid});
      check("cmd_ready",  {31'h0, cmd_ready},
            {31'h0, out_ready & (m_sync != PERIOD - 1) & (m_fifo.size() == 0) & ~rst});
      check("trig_clr",   {31'h0, trig_clr},   {31'h0, (m_age == 2)});
      check("fifo_level", {29'h0, fifo_level}, m_fifo.size());
      check("trig_ovf",   {31'h0, trig_ovf},   {31'h0, m_ovf});
    end
  end

  // --------------------------------------------------------------------------
  // Driver: phases of quiet run, random traffic, overflow with a stalled
  // consumer, drain, a stalled fill interrupted by reset, random traffic.
  // --------------------------------------------------------------------------
  initial begin : p_drive
    bit          trig_on  = 1'b0;
    bit          clr_seen = 1'b0;
    bit          enc_pend = 1'b0;
    bit          cmd_tx;
    logic [15:0] nxt_word = 16'h0;
    int          p_trig;
    int          p_cmd;
    int          p_rdy;

    repeat (3) @(posedge clk160);
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk160);
      cmd_tx = cmd_valid & cmd_ready;
      @(posedge clk160);
      #2;
      if (cyc < 100)                         begin p_rdy = 100; p_trig = 0;  p_cmd = 0;  end
      else if (cyc >= 1000 && cyc < 1150)    begin p_rdy = 0;   p_trig = 30; p_cmd = 0;  end
      else if (cyc >= 1150 && cyc < 1300)    begin p_rdy = 100; p_trig = 0;  p_cmd = 40; end
      else if (cyc >= 1300 && cyc <= RST_AT) begin p_rdy = 0;   p_trig = 30; p_cmd = 0;  end
      else                                   begin p_rdy = 80;  p_trig = 8;  p_cmd = 30; end

      rst       = (cyc == RST_AT);
      out_ready = ($urandom_range(0, 99) < p_rdy);

      // Encoder: enc_trig follows trigger_rdy by one cycle; release after
      // trig_clr has been seen and the capture edge has passed.
      if (enc_pend) begin
        enc_trig = nxt_word;
        enc_pend = 1'b0;
      end
      if (trig_on) begin
        if (clr_seen) begin
          trigger_rdy = 1'b0;
          trig_on     = 1'b0;
          clr_seen    = 1'b0;
        end else if (trig_clr) begin
          clr_seen = 1'b1;
        end
      end else if ($urandom_range(0, 99) < p_trig) begin
        trigger_rdy = 1'b1;
        trig_on     = 1'b1;
        nxt_word    = 16'($urandom_range(1, 16'hFFFF));
        enc_pend    = 1'b1;
      end

      // Command source: hold each word until it transfers.
      if (cmd_valid && cmd_tx) cmd_valid = 1'b0;
      if (!cmd_valid && ($urandom_range(0, 99) < p_cmd)) begin
        cmd_valid = 1'b1;
        cmd_data  = 16'($urandom);
      end
    end

    repeat (4) @(posedge clk160);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_trig_cmd_merge
`default_nettype wire
